// File: rtl/nina_share_decoder.sv
// Sequential unmasking and consistency checking for NINA masked, repetition-encoded bits.
// Shares are folded one per cycle so no combinational cone ever combines all shares.
module nina_share_decoder #(
  parameter int D = 2,
  parameter int K = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(D+1)*(K+1)-1:0] in_shares,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_data,
  output logic                 out_fault,
  output logic                 alarm
);

  localparam int W  = K + 1;
  localparam int N  = D + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] FOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [N*W-1:0] share_q, share_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flt_q, flt_d;
  logic          alarm_q, alarm_d;

  logic [W-1:0]  curShare;
  logic [W-1:0]  accNext;
  logic          shareBad;
  logic          accBad;

  // A repetition codeword is valid only when all of its bits agree.
  always_comb begin
    curShare = share_q[int'(cnt_q)*W +: W];
    accNext  = acc_q ^ curShare;
    shareBad = ~((&curShare) | ~(|curShare));
    accBad   = ~((&accNext) | ~(|accNext));
  end

  always_comb begin
    state_d = state_q;
    share_d = share_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    flt_d   = flt_q;
    alarm_d = alarm_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (in_valid) begin
          share_d = in_shares;
          acc_d   = '0;
          cnt_d   = '0;
          flt_d   = 1'b0;
          state_d = FOLD;
        end
      end
      FOLD: begin
        acc_d = accNext;
        flt_d = flt_q | shareBad;
        cnt_d = cnt_q + 1'b1;
        // Last share: wipe the stored shares and also check the recombined codeword.
        if (int'(cnt_q) == D) begin
          flt_d   = flt_q | shareBad | accBad;
          share_d = '0;
          cnt_d   = '0;
          alarm_d = alarm_q | flt_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          flt_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      share_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      flt_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      share_q <= share_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
      alarm_q <= alarm_d;
    end
  end

  // Outputs decode registered state only, so in_shares never reaches a port combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) & ~flt_q & acc_q[0];
  assign out_fault = (state_q == DONE) & flt_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_nina_share_decoder.sv
// Directed self-checking bench for nina_share_decoder at D=2, K=1.
// Expected results are hand-computed XORs of the three 2-bit shares.
module tb_nina_share_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_shares;
  logic       out_valid;
  logic       out_ready;
  logic       out_data;
  logic       out_fault;
  logic       alarm;

  int nAsserts = 0;
  int nFails   = 0;

  nina_share_decoder #(.D(2), .K(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_shares (in_shares),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_fault (out_fault),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Full transaction with out_ready already high: accept, wait out the fold, check, hand off.
  task automatic applyStimulus(input logic [5:0] shares, input logic expData,
                               input logic expFault, input string tag);
    int cycles;
    in_shares = shares;
    in_valid  = 1'b1;
    stepCycle();
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, int'(in_ready), 0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      stepCycle();
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, 3);
    checkOutput({tag, "_data"}, int'(out_data), int'(expData));
    checkOutput({tag, "_fault"}, int'(out_fault), int'(expFault));
    stepCycle();
    checkOutput({tag, "_valid_drop"}, int'(out_valid), 0);
    checkOutput({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_shares = 6'b111111;
    out_ready = 1'b0;
    repeat (3) stepCycle();
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_fault", int'(out_fault), 0);
    checkOutput("rst_alarm", int'(alarm), 0);

    in_valid = 1'b0;
    rst_n    = 1'b1;
    checkOutput("init_in_ready", int'(in_ready), 0);
    stepCycle();
    checkOutput("idle_in_ready", int'(in_ready), 1);

    out_ready = 1'b1;
    applyStimulus(6'b110011, 1'b0, 1'b0, "xor_zero");

    // Back-to-back with in_valid held high; shares change after the first accept.
    in_shares = 6'b111111;
    in_valid  = 1'b1;
    stepCycle();
    in_shares = 6'b110000;
    stepCycle();
    stepCycle();
    checkOutput("b2b_a_not_yet", int'(out_valid), 0);
    stepCycle();
    checkOutput("b2b_a_valid", int'(out_valid), 1);
    checkOutput("b2b_a_data", int'(out_data), 1);
    checkOutput("b2b_a_busy", int'(in_ready), 0);
    stepCycle();
    checkOutput("b2b_handshake_idle", int'(in_ready), 1);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("b2b_b_accepted", int'(in_ready), 0);
    stepCycle();
    stepCycle();
    checkOutput("b2b_b_not_yet", int'(out_valid), 0);
    stepCycle();
    checkOutput("b2b_b_valid", int'(out_valid), 1);
    checkOutput("b2b_b_data", int'(out_data), 1);
    checkOutput("b2b_b_fault", int'(out_fault), 0);
    stepCycle();
    checkOutput("b2b_b_done", int'(out_valid), 0);

    applyStimulus(6'b100000, 1'b0, 1'b1, "fault");
    checkOutput("fault_alarm", int'(alarm), 1);
    applyStimulus(6'b111111, 1'b1, 1'b0, "post_fault");
    checkOutput("alarm_sticky", int'(alarm), 1);

    // Backpressure: result must hold steady while out_ready stays low.
    out_ready = 1'b0;
    in_shares = 6'b001100;
    in_valid  = 1'b1;
    stepCycle();
    in_valid = 1'b0;
    repeat (3) stepCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_data", int'(out_data), 1);
      checkOutput("bp_fault", int'(out_fault), 0);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      stepCycle();
    end
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_release_valid", int'(out_valid), 0);
    checkOutput("bp_release_idle", int'(in_ready), 1);

    // Reset in the second FOLD cycle of a faulty transaction.
    in_shares = 6'b100000;
    in_valid  = 1'b1;
    stepCycle();
    in_valid = 1'b0;
    stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_alarm", int'(alarm), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("midrst_no_valid", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    stepCycle();
    checkOutput("midrst_recover", int'(in_ready), 1);
    checkOutput("midrst_alarm_after", int'(alarm), 0);
    applyStimulus(6'b001100, 1'b1, 1'b0, "after_reset");
    checkOutput("final_alarm", int'(alarm), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
